rr_encoder32_5: RTL and testbench

- 32-to-5 round-robin priority encoder with a pending-request register and a valid/ready output handshake.
- The inverse of the 5:32 register-select decoder: it collapses a multi-hot 32-bit event vector into a stream of 5-bit indices.
- Sits in the CPU datapath wherever per-register or per-source flags must be serviced one index at a time, e.g. scoreboard release or pending-writeback draining.

---
 rtl/rr_enc_pkg.sv | 19 +
 rtl/rr_pick32.sv | 39 +++
 rtl/rr_encoder32_5.sv | 101 ++++++++++
 tb/tb_rr_encoder32_5.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_enc_pkg.sv
// Shared types and constants for the 32-to-5 round-robin encoder.
//   WIDTH/IDX_W : request vector width and index width (fixed at 32/5)
//   rr_state_t  : offer FSM states
//   req_vec_t   : 32-bit request/pending vector
//   idx_t       : 5-bit encoded index
package rr_enc_pkg;

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } rr_state_t;

    typedef logic [WIDTH-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/rr_pick32.sv
// Combinational round-robin pick over a 32-bit pending vector.
//   pending : in  - request vector to choose from
//   ptr     : in  - first index eligible in this round
//   idx     : out - lowest pending index >= ptr, else lowest pending overall
//   found   : out - at least one bit of pending is set
module rr_pick32
    import rr_enc_pkg::*;
(
    input  req_vec_t pending,
    input  idx_t     ptr,
    output idx_t     idx,
    output logic     found
);

    req_vec_t mask;
    req_vec_t masked;
    idx_t     masked_idx;
    idx_t     full_idx;

    always_comb begin
        mask       = {WIDTH{1'b1}} << ptr;
        masked     = pending & mask;
        masked_idx = '0;
        full_idx   = '0;
        // Scanning downward leaves the lowest set bit as the final assignment.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (masked[i]) begin
                masked_idx = idx_t'(i);
            end
            if (pending[i]) begin
                full_idx = idx_t'(i);
            end
        end
        found = |pending;
        // Nothing at or above ptr: wrap to the lowest pending bit.
        idx   = (|masked) ? masked_idx : full_idx;
    end

endmodule

// File: rtl/rr_encoder32_5.sv
// 32-to-5 round-robin priority encoder with pending register and
// valid/ready output handshake.
//   clk       : in  - rising-edge clock
//   reset_n   : in  - asynchronous active-low reset
//   set       : in  - per-bit requests, OR'd into pending each edge
//   clr_all   : in  - synchronous flush of pending and the offer
//   out_ready : in  - consumer accepts out_idx this cycle
//   out_valid : out - out_idx carries an offered request
//   out_idx   : out - encoded index being offered (held while idle)
//   pending   : out - registered pending vector
//   pend_cnt  : out - popcount of pending (0..32)
//
// state | meaning
// IDLE  | no offer outstanding; picks next index when pending != 0
// OFFER | out_idx presented, waiting for out_ready
module rr_encoder32_5
    import rr_enc_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   set,
    input  logic               clr_all,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_idx,
    output logic [WIDTH-1:0]   pending,
    output logic [IDX_W:0]     pend_cnt
);

    rr_state_t    state_q;
    req_vec_t     pending_q;
    req_vec_t     pending_d;
    req_vec_t     clear_mask;
    idx_t         ptr_q;
    idx_t         out_idx_q;
    idx_t         pick_idx;
    logic         pick_found;
    logic         handshake;
    logic [IDX_W:0] cnt;

    rr_pick32 u_pick (
        .pending (pending_q),
        .ptr     (ptr_q),
        .idx     (pick_idx),
        .found   (pick_found)
    );

    assign handshake = (state_q == OFFER) && out_ready && !clr_all;

    always_comb begin
        clear_mask = '0;
        if (handshake) begin
            clear_mask[out_idx_q] = 1'b1;
        end
        // A new set of the bit being retired wins, so it is re-offered later.
        pending_d = clr_all ? '0 : ((pending_q & ~clear_mask) | set);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            out_idx_q <= '0;
        end else begin
            pending_q <= pending_d;
            if (clr_all) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pick_found) begin
                            out_idx_q <= pick_idx;
                            state_q   <= OFFER;
                        end
                    end
                    OFFER: begin
                        if (out_ready) begin
                            ptr_q   <= out_idx_q + idx_t'(1);
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + (IDX_W+1)'(pending_q[i]);
        end
    end

    assign out_valid = (state_q == OFFER);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign pend_cnt  = cnt;

endmodule

// File: tb/tb_rr_encoder32_5.sv
module tb_rr_encoder32_5;

    logic        clk;
    logic        reset_n;
    logic [31:0] set;
    logic        clr_all;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  out_idx;
    logic [31:0] pending;
    logic [5:0]  pend_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rr_encoder32_5 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .set       (set),
        .clr_all   (clr_all),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for an offer, checks its index, then takes the handshake edge.
    task automatic grant(input string tag, input logic [4:0] exp_idx);
        int t = 0;
        while (out_valid !== 1'b1 && t < 8) begin
            tick();
            t++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_idx"}, 32'(out_idx), 32'(exp_idx));
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        set       = '0;
        clr_all   = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_cnt", 32'(pend_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset asserted mid-offer acts without a clock edge.
        set = 32'h0000_0010;
        tick();
        check("t1_pend", pending, 32'h0000_0010);
        check("t1_cnt", 32'(pend_cnt), 32'd1);
        check("t1_valid0", 32'(out_valid), 32'd0);
        set = '0;
        tick();
        check("t1_valid1", 32'(out_valid), 32'd1);
        check("t1_idx", 32'(out_idx), 32'd4);
        #2 reset_n = 1'b0;
        #1;
        check("t1_rst_valid", 32'(out_valid), 32'd0);
        check("t1_rst_idx", 32'(out_idx), 32'd0);
        check("t1_rst_pend", pending, 32'd0);
        check("t1_rst_cnt", 32'(pend_cnt), 32'd0);
        #2 reset_n = 1'b1;

        // Single request with exact latency.
        out_ready = 1'b1;
        set = 32'h0000_0001;
        tick();
        check("t2_cnt", 32'(pend_cnt), 32'd1);
        check("t2_valid0", 32'(out_valid), 32'd0);
        set = '0;
        tick();
        check("t2_valid1", 32'(out_valid), 32'd1);
        check("t2_idx", 32'(out_idx), 32'd0);
        tick();
        check("t2_valid_done", 32'(out_valid), 32'd0);
        check("t2_pend_done", pending, 32'd0);
        check("t2_idx_hold", 32'(out_idx), 32'd0);

        // ptr is now 1: 0x8000_0005 is served 2, 31, 0.
        set = 32'h8000_0005;
        tick();
        set = '0;
        grant("p1_a", 5'd2);
        grant("p1_b", 5'd31);
        grant("p1_c", 5'd0);
        // ptr 1 -> grant 31 -> ptr wraps to 0.
        set = 32'h8000_0000;
        tick();
        set = '0;
        grant("p1_wrap", 5'd31);

        // Multi-hot from ptr 0 with pend_cnt stepping down.
        set = 32'h8000_0005;
        tick();
        set = '0;
        check("t3_cnt3", 32'(pend_cnt), 32'd3);
        tick();
        check("t3_idx0", 32'(out_idx), 32'd0);
        check("t3_v0", 32'(out_valid), 32'd1);
        tick();
        check("t3_cnt2", 32'(pend_cnt), 32'd2);
        check("t3_pend2", pending, 32'h8000_0004);
        tick();
        check("t3_idx2", 32'(out_idx), 32'd2);
        tick();
        check("t3_cnt1", 32'(pend_cnt), 32'd1);
        tick();
        check("t3_idx31", 32'(out_idx), 32'd31);
        check("t3_v31", 32'(out_valid), 32'd1);
        tick();
        check("t3_cnt0", 32'(pend_cnt), 32'd0);
        check("t3_vend", 32'(out_valid), 32'd0);
        // Final ptr 0: bits 1 and 30 are served 1 then 30 (ptr ends at 31).
        set = 32'h4000_0002;
        tick();
        set = '0;
        grant("t3_ptr_a", 5'd1);
        grant("t3_ptr_b", 5'd30);

        // Round-robin: drain 20 (ptr 21), then 5 wraps ahead of 20.
        set = 32'h0010_0000;
        tick();
        set = '0;
        grant("t4_drain", 5'd20);
        set = 32'h0010_0020;
        tick();
        set = '0;
        grant("t4_first", 5'd5);
        grant("t4_second", 5'd20);

        // Starvation: all-ones held, 64 grants in strict rotation from 21.
        set = 32'hFFFF_FFFF;
        for (int i = 0; i < 64; i++) begin
            grant($sformatf("t4_rot%0d", i), 5'((21 + i) % 32));
        end
        check("t4_cnt32", 32'(pend_cnt), 32'd32);
        set = '0;
        clr_all = 1'b1;
        tick();
        clr_all = 1'b0;
        check("t4_clr_pend", pending, 32'd0);
        check("t4_clr_valid", 32'(out_valid), 32'd0);

        // Backpressure: offer 7 held while 3 and 9 arrive (ptr 21).
        out_ready = 1'b0;
        set = 32'h0000_0080;
        tick();
        set = 32'h0000_0208;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t5_hold_idx%0d", i), 32'(out_idx), 32'd7);
            check($sformatf("t5_hold_v%0d", i), 32'(out_valid), 32'd1);
        end
        check("t5_pend", pending, 32'h0000_0288);
        // Handshake on 7 while set[7] is re-asserted: set wins.
        out_ready = 1'b1;
        set = 32'h0000_0080;
        tick();
        set = '0;
        check("t5_coll_pend", pending, 32'h0000_0288);
        check("t5_coll_valid", 32'(out_valid), 32'd0);
        grant("t5_g9", 5'd9);
        grant("t5_g3", 5'd3);
        grant("t5_g7", 5'd7);

        // Flush during offer of 12 (ptr 8).
        out_ready = 1'b0;
        set = 32'h0000_F000;
        tick();
        set = '0;
        tick();
        check("t6_idx12", 32'(out_idx), 32'd12);
        check("t6_v", 32'(out_valid), 32'd1);
        clr_all = 1'b1;
        set = 32'h0000_0001;
        out_ready = 1'b1;
        tick();
        clr_all = 1'b0;
        set = '0;
        check("t6_pend", pending, 32'd0);
        check("t6_cnt", 32'(pend_cnt), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_idx_hold", 32'(out_idx), 32'd12);
        repeat (3) tick();
        check("t6_quiet", 32'(out_valid), 32'd0);
        // ptr still 8: bits 3 and 10 are served 10 then 3.
        set = 32'h0000_0408;
        tick();
        set = '0;
        grant("t6_ptr_a", 5'd10);
        grant("t6_ptr_b", 5'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
